// File: rtl/mc_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mc_cpu_pkg
// Shared definitions for the multi-cycle CPU: FSM state encodings, opcode
// constants and the select codes for the ALU operation, PC source and ALU
// B-operand muxes. Imported by the control FSM, the datapath and the bench.
// ---------------------------------------------------------------------------
package mc_cpu_pkg;

   typedef enum logic [3:0] {
      S_IF   = 4'd0,
      S_ID   = 4'd1,
      S_MA   = 4'd2,
      S_MR   = 4'd3,
      S_MWB  = 4'd4,
      S_MW   = 4'd5,
      S_EX   = 4'd6,
      S_RWB  = 4'd7,
      S_BR   = 4'd8,
      S_JP   = 4'd9,
      S_IEX  = 4'd10,
      S_IWB  = 4'd11,
      S_HALT = 4'd15
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALU operation class handed to the ALU control
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // PC source mux
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // ALU B operand mux
   localparam logic [1:0] SRC_B_REG      = 2'b00;
   localparam logic [1:0] SRC_B_FOUR     = 2'b01;
   localparam logic [1:0] SRC_B_IMM      = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

   // States whose exit back to IF completes (retires) an instruction
   function automatic logic is_retire_state(input state_t s);
      return (s == S_MWB) || (s == S_MW) || (s == S_RWB) ||
             (s == S_BR)  || (s == S_JP) || (s == S_IWB);
   endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Moore control FSM for a multi-cycle MIPS-style CPU (lw, sw, R-type, beq,
// j, addi). Unknown opcodes send the machine to an absorbing HALT state.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   opcode[5:0]         : IR[31:26] of the latched instruction
//   zero                : ALU zero flag (only used for the beq PC enable)
//   pc_en               : PCWrite | (PCWriteCond & zero)
//   i_or_d              : memory address select (0 = PC, 1 = ALUOut)
//   mem_write, ir_write, reg_write : write strobes
//   reg_dst, mem_to_reg, alu_src_a : mux selects
//   alu_src_b, alu_op, pc_source   : 2-bit mux / ALU selects
//   halted              : high while in HALT
//   state, inst_cnt, cycle_cnt     : debug observation
// ---------------------------------------------------------------------------
module mc_control_fsm
   import mc_cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             zero,
   output logic             pc_en,
   output logic             i_or_d,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             halted,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] inst_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic             pc_write, pc_write_cond;

   // ------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IF;
         inst_cnt_q  <= '0;
         cycle_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         inst_cnt_q  <= inst_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state. The opcode is only looked at in ID and MA, so the
   // datapath may let IR-derived lines wander in every other state.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IF:  state_d = S_ID;
         S_ID: begin
            unique case (opcode)
               OP_LW, OP_SW: state_d = S_MA;
               OP_RTYPE:     state_d = S_EX;
               OP_BEQ:       state_d = S_BR;
               OP_J:         state_d = S_JP;
               OP_ADDI:      state_d = S_IEX;
               default:      state_d = S_HALT;
            endcase
         end
         S_MA:   state_d = (opcode == OP_LW) ? S_MR : S_MW;
         S_MR:   state_d = S_MWB;
         S_MWB:  state_d = S_IF;
         S_MW:   state_d = S_IF;
         S_EX:   state_d = S_RWB;
         S_RWB:  state_d = S_IF;
         S_BR:   state_d = S_IF;
         S_JP:   state_d = S_IF;
         S_IEX:  state_d = S_IWB;
         S_IWB:  state_d = S_IF;
         S_HALT: state_d = S_HALT;
         // Unused encodings collapse into HALT rather than running on.
         default: state_d = S_HALT;
      endcase
   end

   // ------------------------------------------------------------------
   // Counters: every retire state exits to IF, so retiring is a pure
   // function of the current state. Both counters wrap naturally.
   // ------------------------------------------------------------------
   always_comb begin
      inst_cnt_d  = inst_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      if (is_retire_state(state_q)) begin
         inst_cnt_d = inst_cnt_q + 1'b1;
      end
      if (state_q != S_HALT) begin
         cycle_cnt_d = cycle_cnt_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Moore output decode (everything defaults to 0)
   // ------------------------------------------------------------------
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_REG;
      alu_op        = ALU_OP_ADD;
      pc_source     = PC_SRC_ALU;
      halted        = 1'b0;
      unique case (state_q)
         S_IF: begin
            ir_write  = 1'b1;
            alu_src_b = SRC_B_FOUR;
            pc_write  = 1'b1;
         end
         S_ID: begin
            // Branch target precompute: PC + (imm << 2)
            alu_src_b = SRC_B_IMM_SHL2;
         end
         S_MA: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         S_MR: begin
            i_or_d = 1'b1;
         end
         S_MWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MW: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         S_EX: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_FUNCT;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BR: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_OP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PC_SRC_ALUOUT;
         end
         S_JP: begin
            pc_write  = 1'b1;
            pc_source = PC_SRC_JUMP;
         end
         S_IEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         S_IWB: begin
            reg_write = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign pc_en     = pc_write | (pc_write_cond & zero);
   assign state     = state_q;
   assign inst_cnt  = inst_cnt_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule
